// File: rtl/xor_net_solver_if.sv
// Stream and config bundle for xor_net_solver.
// master: the surrounding datapath that loads P, sends s and accepts c.
// slave:  the solver itself.
interface xor_net_solver_if #(
    parameter int unsigned N  = 14,
    parameter int unsigned RW = $clog2(N)
);
    logic          cfg_we;
    logic [RW-1:0] cfg_row;
    logic [N-1:0]  cfg_data;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  s;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  c;
    logic          singular;
    logic          check_err;

    modport master (
        output cfg_we, cfg_row, cfg_data, in_valid, s, out_ready,
        input  in_ready, out_valid, c, singular, check_err
    );

    modport slave (
        input  cfg_we, cfg_row, cfg_data, in_valid, s, out_ready,
        output in_ready, out_valid, c, singular, check_err
    );
endinterface

// File: rtl/xor_net_solver.sv
// xor_net_solver: recovers c from s = P*c over GF(2) by sequential Gauss-Jordan
// elimination, one PIVOT and one ELIM cycle per column.
// Optional macro XOR_NET_SOLVER_SELFCHECK_EN adds a CHECK state that re-encodes
// the result with the stored P and flags a mismatch on check_err.
module xor_net_solver #(
    parameter int unsigned N  = 14,
    parameter int unsigned RW = $clog2(N)
) (
    input logic              clk,
    input logic              rst_n,
    xor_net_solver_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StLoad, StPivot, StElim, StCheck, StDone} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  p_q [N];
    logic [N-1:0]  p_d [N];
    logic [N-1:0]  w_q [N];
    logic [N-1:0]  w_d [N];
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  s_q, s_d;
    logic [RW-1:0] col_q, col_d;
    logic          sing_q, sing_d;
    logic          skip_q, skip_d;
`ifdef XOR_NET_SOLVER_SELFCHECK_EN
    logic          chk_q, chk_d;
    logic [N-1:0]  enc;
`endif

    logic          accept;
    logic          piv_found;
    logic [RW-1:0] piv_row;
    logic          last_col;

    assign accept   = (state_q == StIdle) && bus.in_valid;
    assign last_col = (col_q == RW'(N - 1));

    // State register with synchronous reset; reset restores identity P.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            s_q     <= '0;
            col_q   <= '0;
            sing_q  <= 1'b0;
            skip_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                p_q[i] <= N'(1) << i;
                w_q[i] <= '0;
            end
`ifdef XOR_NET_SOLVER_SELFCHECK_EN
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            s_q     <= s_d;
            col_q   <= col_d;
            sing_q  <= sing_d;
            skip_q  <= skip_d;
            p_q     <= p_d;
            w_q     <= w_d;
`ifdef XOR_NET_SOLVER_SELFCHECK_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Next-state logic for the solve sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLoad;
            StLoad:  state_d = StPivot;
            StPivot: state_d = StElim;
            StElim: begin
                if (last_col) begin
`ifdef XOR_NET_SOLVER_SELFCHECK_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StPivot;
                end
            end
            StCheck: state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lowest row at or below col with a 1 in column col.
    always_comb begin
        piv_found = 1'b0;
        piv_row   = '0;
        for (int r = N - 1; r >= 0; r--) begin
            if (r >= int'(col_q) && w_q[r][col_q]) begin
                piv_found = 1'b1;
                piv_row   = RW'(r);
            end
        end
    end

`ifdef XOR_NET_SOLVER_SELFCHECK_EN
    // Re-encode the solved word with the stored P.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            enc[i] = ^(p_q[i] & a_q);
        end
    end
`endif

    // Datapath: config writes, load, row swap and parallel elimination.
    always_comb begin
        p_d    = p_q;
        w_d    = w_q;
        a_d    = a_q;
        s_d    = s_q;
        col_d  = col_q;
        sing_d = sing_q;
        skip_d = skip_q;
`ifdef XOR_NET_SOLVER_SELFCHECK_EN
        chk_d  = chk_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.cfg_we && (int'(bus.cfg_row) < N)) p_d[bus.cfg_row] = bus.cfg_data;
                if (accept) s_d = bus.s;
            end
            StLoad: begin
                w_d    = p_q;
                a_d    = s_q;
                col_d  = '0;
                sing_d = 1'b0;
            end
            StPivot: begin
                if (piv_found) begin
                    // piv_row == col degenerates to a no-op rewrite
                    w_d[col_q]   = w_q[piv_row];
                    w_d[piv_row] = w_q[col_q];
                    a_d[col_q]   = a_q[piv_row];
                    a_d[piv_row] = a_q[col_q];
                    skip_d       = 1'b0;
                end else begin
                    sing_d = 1'b1;
                    skip_d = 1'b1;
                end
            end
            StElim: begin
                if (!skip_q) begin
                    for (int i = 0; i < N; i++) begin
                        if (i != int'(col_q) && w_q[i][col_q]) begin
                            w_d[i] = w_q[i] ^ w_q[col_q];
                            a_d[i] = a_q[i] ^ a_q[col_q];
                        end
                    end
                end
                col_d = col_q + RW'(1);
            end
`ifdef XOR_NET_SOLVER_SELFCHECK_EN
            StCheck: chk_d = (enc != s_q) || sing_q;
`endif
            default: ;
        endcase
    end

    // Outputs are decoded from state; results only show while DONE.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.c         = (state_q == StDone) ? a_q : '0;
        bus.singular  = (state_q == StDone) && sing_q;
`ifdef XOR_NET_SOLVER_SELFCHECK_EN
        bus.check_err = (state_q == StDone) && chk_q;
`else
        bus.check_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_xor_net_solver.sv
// Directed bench for xor_net_solver with a result scoreboard.
module tb_xor_net_solver;
    localparam int N = 14;
`ifdef XOR_NET_SOLVER_SELFCHECK_EN
    localparam int Lat = 2 * N + 2;
    localparam logic SelfChk = 1'b1;
`else
    localparam int Lat = 2 * N + 1;
    localparam logic SelfChk = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] c;
        logic         chk_c;
        logic         singular;
        logic         check_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [N-1:0] pm [N];

    xor_net_solver_if #(.N(N)) bus ();

    xor_net_solver #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] encode(input logic [N-1:0] cv);
        logic [N-1:0] sv;
        for (int i = 0; i < N; i++) sv[i] = ^(pm[i] & cv);
        return sv;
    endfunction

    task automatic set_row(input int row, input logic [N-1:0] data);
        pm[row] = data;
        bus.cfg_we   = 1'b1;
        bus.cfg_row  = 4'(row);
        bus.cfg_data = data;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic start_solve(input logic [N-1:0] sv, input logic [N-1:0] ce,
                               input logic chk_c, input logic sing, input logic cerr);
        exp_t e;
        e.c = ce; e.chk_c = chk_c; e.singular = sing; e.check_err = cerr;
        sb.push_back(e);
        check("accept_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.s = sv;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic finish_solve(input int hold, input logic poke);
        int n = 0;
        exp_t e;
        logic [N-1:0] c0;
        logic s0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        if (bus.out_valid !== 1'b1) begin
            check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
            return;
        end
        check("latency", 32'(cyc - acc_cyc), 32'(Lat));
        if (e.chk_c) check("c", 32'(bus.c), 32'(e.c));
        check("singular", 32'(bus.singular), 32'(e.singular));
        check("check_err", 32'(bus.check_err), 32'(e.check_err));
        c0 = bus.c;
        s0 = bus.singular;
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.s = 14'h3FFF;
            end
            @(posedge clk); #1;
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_c", 32'(bus.c), 32'(c0));
            check("hold_singular", 32'(bus.singular), 32'(s0));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [N-1:0] cv;
        bus.cfg_we = 1'b0; bus.cfg_row = '0; bus.cfg_data = '0;
        bus.in_valid = 1'b0; bus.s = '0; bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) pm[i] = 14'(1) << i;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_c", 32'(bus.c), 32'd0);
        check("rst_singular", 32'(bus.singular), 32'd0);
        check("rst_check_err", 32'(bus.check_err), 32'd0);

        // Identity P after reset
        start_solve(14'h2A5B, 14'h2A5B, 1'b1, 1'b0, 1'b0);
        finish_solve(0, 1'b0);

        // Bit-reversal P: c is s reversed
        for (int i = 0; i < N; i++) set_row(i, 14'(1) << (N - 1 - i));
        start_solve(14'h0001, 14'h2000, 1'b1, 1'b0, 1'b0);
        finish_solve(0, 1'b0);
        start_solve(14'h0006, 14'h1800, 1'b1, 1'b0, 1'b0);
        finish_solve(0, 1'b0);

        // Full-rank P needing row swaps; s produced by forward encoding
        for (int i = 0; i < N - 1; i++)
            set_row(i, (14'(1) << (N - 1 - i)) | (14'(1) << (N - 2 - i)));
        set_row(N - 1, 14'h0001);
        for (int k = 0; k < 3; k++) begin
            cv = 14'($urandom);
            start_solve(encode(cv), cv, 1'b1, 1'b0, 1'b0);
            finish_solve(0, 1'b0);
        end

        // Backpressure: results held, no accept while DONE
        start_solve(encode(14'h1C3A), 14'h1C3A, 1'b1, 1'b0, 1'b0);
        finish_solve(5, 1'b1);

        // Singular P: rows 0 and 1 equal
        for (int i = 0; i < N; i++) set_row(i, 14'(1) << i);
        set_row(0, 14'h0003);
        set_row(1, 14'h0003);
        start_solve(14'h0001, 14'h0000, 1'b0, 1'b1, SelfChk);
        finish_solve(2, 1'b0);

        // Reset at cycle 10 of a solve aborts it and restores identity P
        bus.in_valid = 1'b1;
        bus.s = 14'h0155;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) pm[i] = 14'(1) << i;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_c", 32'(bus.c), 32'd0);
        repeat (Lat) @(posedge clk);
        #1 check("abort_no_output", 32'(bus.out_valid), 32'd0);
        start_solve(14'h1234, 14'h1234, 1'b1, 1'b0, 1'b0);
        finish_solve(0, 1'b0);

        // Config write during ELIM is dropped
        start_solve(14'h0001, 14'h0001, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.cfg_we = 1'b1; bus.cfg_row = 4'd0; bus.cfg_data = 14'h0002;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        finish_solve(0, 1'b0);
        start_solve(14'h0001, 14'h0001, 1'b1, 1'b0, 1'b0);
        finish_solve(0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
